// File: rtl/ex_shift_seq_pkg.sv
// Shared definitions for the EX-stage multi-cycle shift sequencer:
// ALU op encodings, sequencer states and the decoded shift class.
package ex_shift_seq_pkg;

   localparam logic [7:0] EXE_SLL_OP = 8'b0111_1100;
   localparam logic [7:0] EXE_SRL_OP = 8'b0000_0010;
   localparam logic [7:0] EXE_SRA_OP = 8'b0000_0011;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StShift = 2'd1,
      StDone  = 2'd2
   } seqState_e;

   typedef enum logic [1:0] {
      OpSll     = 2'd0,
      OpSrl     = 2'd1,
      OpSra     = 2'd2,
      OpInvalid = 2'd3
   } opClass_e;

   function automatic opClass_e decodeOp(input logic [7:0] aluOp);
      opClass_e cls;
      case (aluOp)
         EXE_SLL_OP: cls = OpSll;
         EXE_SRL_OP: cls = OpSrl;
         EXE_SRA_OP: cls = OpSra;
         default:    cls = OpInvalid;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/ex_shift_step.sv
// Combinational single step of the shift datapath: moves the operand by
// BIG_STEP or by one bit, filling with zeros or the latched sign.
module ex_shift_step
   import ex_shift_seq_pkg::*;
#(
   parameter int BIG_STEP = 4
) (
   input  logic [31:0] data_i,
   input  opClass_e    opClass_i,
   input  logic        sign_i,
   input  logic        big_i,
   output logic [31:0] data_o
);

   // Masks covering the bit positions vacated at the high end by a right shift.
   localparam logic [31:0] BigFill = ~(32'hFFFF_FFFF >> BIG_STEP);
   localparam logic [31:0] OneFill = 32'h8000_0000;

   logic [31:0] fillMask;

   always_comb begin
      fillMask = big_i ? BigFill : OneFill;
      data_o   = data_i;
      case (opClass_i)
         OpSll:   data_o = big_i ? (data_i << BIG_STEP) : (data_i << 1);
         OpSrl:   data_o = big_i ? (data_i >> BIG_STEP) : (data_i >> 1);
         OpSra:   data_o = (big_i ? (data_i >> BIG_STEP) : (data_i >> 1))
                           | (fillMask & {32{sign_i}});
         default: data_o = data_i;
      endcase
   end

endmodule

// File: rtl/ex_shift_seq.sv
// Multi-cycle SLL/SRL/SRA sequencer for the EX stage: iterates ex_shift_step
// until the shift amount is consumed, stalling the pipeline meanwhile.
module ex_shift_seq
   import ex_shift_seq_pkg::*;
#(
   parameter int BIG_STEP = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start_i,
   input  logic [7:0]  alu_op_i,
   input  logic [31:0] reg1_i,
   input  logic [31:0] reg2_i,
   input  logic        flush_i,
   output logic        ready_o,
   output logic        stall_o,
   output logic        valid_o,
   output logic [31:0] result_o
);

   localparam logic [4:0] BigStepW = 5'(BIG_STEP);

   seqState_e   state_q, state_d;
   opClass_e    opClass_q, opClass_d;
   logic [31:0] data_q, data_d;
   logic [4:0]  remaining_q, remaining_d;
   logic        sign_q, sign_d;
   logic [31:0] result_q, result_d;
   logic        valid_q, valid_d;

   logic        accept;
   logic        stepBig;
   logic [31:0] stepOut;
   logic        unusedReg1;

   assign unusedReg1 = ^reg1_i[31:5];

   ex_shift_step #(
      .BIG_STEP (BIG_STEP)
   ) u_step (
      .data_i    (data_q),
      .opClass_i (opClass_q),
      .sign_i    (sign_q),
      .big_i     (stepBig),
      .data_o    (stepOut)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= StIdle;
         opClass_q   <= OpInvalid;
         data_q      <= '0;
         remaining_q <= '0;
         sign_q      <= 1'b0;
         result_q    <= '0;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         opClass_q   <= opClass_d;
         data_q      <= data_d;
         remaining_q <= remaining_d;
         sign_q      <= sign_d;
         result_q    <= result_d;
         valid_q     <= valid_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      opClass_d   = opClass_q;
      data_d      = data_q;
      remaining_d = remaining_q;
      sign_d      = sign_q;
      result_d    = result_q;
      valid_d     = 1'b0;
      accept      = (state_q == StIdle) && start_i && !flush_i;
      stepBig     = (remaining_q >= BigStepW);

      case (state_q)
         StIdle: begin
            if (accept) begin
               opClass_d   = decodeOp(alu_op_i);
               sign_d      = reg2_i[31];
               remaining_d = reg1_i[4:0];
               if (decodeOp(alu_op_i) == OpInvalid) begin
                  data_d  = '0;
                  state_d = StDone;
               end else begin
                  data_d  = reg2_i;
                  state_d = (reg1_i[4:0] == 5'd0) ? StDone : StShift;
               end
            end
         end
         StShift: begin
            data_d      = stepOut;
            remaining_d = remaining_q - (stepBig ? BigStepW : 5'd1);
            if (remaining_d == 5'd0) begin
               state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase

      // Flush wins over everything; the result register only moves on completion.
      if (flush_i) begin
         state_d = StIdle;
      end
      if (state_d == StDone) begin
         valid_d  = 1'b1;
         result_d = data_d;
      end
   end

   assign ready_o  = (state_q == StIdle);
   assign stall_o  = resetn && !flush_i &&
                     (((state_q == StIdle) && start_i) || (state_q == StShift));
   assign valid_o  = valid_q;
   assign result_o = result_q;

endmodule

// File: doc/ex_shift_seq.md
# ex_shift_seq

Multi-cycle sequencer for a reduced-area shift datapath in the EX stage. It accepts SLL/SRL/SRA requests from the EX issue logic, iterates a small step shifter (BIG_STEP or 1 bit per cycle) until the shift amount is consumed, and holds the pipeline with a stall request meanwhile. Results match the single-cycle shift semantics exactly, including a zero result for unsupported ops. Flush from the pipeline controller aborts an operation in flight.

## Interface

Parameters:
- BIG_STEP, 4: large step size in bits; power of two, 2..16.

Ports:
- clk  in  1  rising-edge clock.
- resetn  in  1  reset, asynchronous, active-low.
- start_i  in  1  EX stage holds a shift instruction.
- alu_op_i  in  8  `EXE_SLL_OP` / `EXE_SRL_OP` / `EXE_SRA_OP`; any other op produces result 0.
- reg1_i  in  32  shift amount source; only [4:0] is used.
- reg2_i  in  32  operand to shift.
- flush_i  in  1  pipeline flush; aborts and returns to IDLE.
- ready_o  out  1  state is IDLE.
- stall_o  out  1  stall request to the pipeline controller.
- valid_o  out  1  one-cycle pulse: result_o is final.
- result_o  out  32  shift result; held until the next accept.

## Operation

- States: IDLE, SHIFT, DONE.
- Accept: state IDLE, start_i=1, flush_i=0. On accept, latch:
  - op class: SLL, SRL, SRA or INVALID;
  - data := reg2_i;
  - remaining := reg1_i[4:0];
  - sign := reg2_i[31].
- On accept, next state:
  - INVALID op: DONE, with result 0 latched.
  - remaining=0: DONE, with data unchanged.
  - otherwise: SHIFT.
- SHIFT, one step per cycle:
  - remaining >= BIG_STEP: shift by BIG_STEP, remaining -= BIG_STEP.
  - otherwise: shift by 1, remaining -= 1.
  - Fill bits: SLL fills zeros at the low end; SRL fills zeros at the high end; SRA fills with the latched sign.
  - When remaining becomes 0, the next state is DONE.
- DONE:
  - valid_o=1 and result_o=data.
  - Next state is IDLE unconditionally.
  - start_i in DONE is ignored; it is the same, completing instruction.
- flush_i=1 in any state:
  - next state is IDLE;
  - valid_o is not asserted;
  - result_o is not updated.
- Step count N(n) = floor(n/BIG_STEP) + (n mod BIG_STEP). With BIG_STEP=4: N(31)=10 (maximum), N(5)=2.
- Result arithmetic is modulo 32 bits. The final value equals reg2_i shifted by reg1_i[4:0] under single-cycle semantics (SRA = logical right shift OR sign fill).

## Timing

- Reset (resetn low, asynchronous): state IDLE, data 0, remaining 0, result_o 0, valid_o 0. stall_o is 0 and ready_o is 1 while reset is asserted.
- stall_o is combinational: (IDLE & start_i & !flush_i) | SHIFT. It is 0 in DONE, so the pipeline advances at the end of the DONE cycle.
- Latency: accept in cycle T; DONE (valid_o=1) in cycle T+1+N(n). INVALID op or n=0 reaches DONE in T+1.
- valid_o is registered, asserted exactly one cycle per completed operation. result_o is registered and stable from DONE until the next accept.
- Reset asserted mid-SHIFT: immediate return to IDLE with outputs at reset values; no valid_o afterwards.
- flush_i in the accept cycle: no accept, stall_o=0.
- A new accept is possible in the cycle after DONE, so back-to-back operations have one idle-free turnaround.

## Structure

- Shared defines: `EXE_SLL_OP`, `EXE_SRL_OP`, `EXE_SRA_OP` (existing ALU op encodings), plus the state encoding for IDLE, SHIFT and DONE.
- Sub-module ex_shift_step: combinational single step.
  - Inputs: data, op class, sign, big/small select.
  - Output: data shifted by BIG_STEP or 1 with the correct fill.
  - The sequencer owns all state, counters and handshake.

## Test plan

- SRA 0x80000000 by 5, accept at T: stall_o high T..T+2; valid_o at T+3; result 0xFC000000.
- SLL 0x00000001 by 31: valid_o at T+11 (10 steps); result 0x80000000. SRL 0xF0000000 by 4: valid_o at T+2; result 0x0F000000.
- Shift by 0 (reg1_i=0x20, amount field 0) with reg2_i=0x12345678: valid_o at T+1, result 0x12345678. Unsupported op: valid_o at T+1, result 0.
- flush_i at T+2 of a 31-bit shift: state IDLE at T+3; no valid_o; result_o keeps its previous value; stall_o low from T+2.
- resetn pulled low mid-SHIFT asynchronously: outputs go to reset values immediately. After release, a new SRL 0xFFFFFFFF by 1 gives 0x7FFFFFFF.
- Back-to-back: two accepts with one DONE cycle between them. Each produces exactly one valid_o pulse with the correct result, and no start_i is accepted during DONE.
